// File: rtl/valid_data_array_if.sv
// rtl/valid_data_array_if.sv - access bus for the valid/data storage array
interface valid_data_array_if #(
    parameter int WIDTH       = 128,
    parameter int INDEX_WIDTH = 3
);
    logic                   write;
    logic [INDEX_WIDTH-1:0] index;
    logic [WIDTH-1:0]       datain;
    logic [WIDTH/8-1:0]     byte_en;
    logic                   invalidate;
    logic                   flush_all;
    logic [WIDTH-1:0]       dataout;
    logic                   valid_out;
    logic                   busy;

    modport master (
        output write, index, datain, byte_en, invalidate, flush_all,
        input  dataout, valid_out, busy
    );

    modport slave (
        input  write, index, datain, byte_en, invalidate, flush_all,
        output dataout, valid_out, busy
    );
endinterface

// File: rtl/valid_data_array.sv
// rtl/valid_data_array.sv - byte-writable storage array with per-entry valid bits and sequential flush
module valid_data_array #(
    parameter int WIDTH       = 128,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    valid_data_array_if.slave   bus
);
    localparam int DEPTH  = 2 ** INDEX_WIDTH;
    localparam int NBYTES = WIDTH / 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    // Data is power-up zero and deliberately survives reset; only valid bits are reset.
    logic [WIDTH-1:0]       mem [DEPTH] = '{default: '0};
    logic [DEPTH-1:0]       valid;
    logic [0:0]             state;
    logic [INDEX_WIDTH-1:0] flush_cnt;
    logic                   busy;

    assign busy          = (state == FLUSH);
    assign bus.busy      = busy;
    assign bus.dataout   = mem[bus.index];
    assign bus.valid_out = valid[bus.index] & ~busy;

    always_ff @(posedge clk) begin
        if (bus.write && !busy) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (bus.byte_en[b]) begin
                    mem[bus.index][8*b +: 8] <= bus.datain[8*b +: 8];
                end
            end
        end
    end

    // Invalidate is assigned last so it wins over a same-cycle write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (busy) begin
            valid[flush_cnt] <= 1'b0;
        end else begin
            if (bus.write && (|bus.byte_en)) begin
                valid[bus.index] <= 1'b1;
            end
            if (bus.invalidate) begin
                valid[bus.index] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    flush_cnt <= '0;
                    if (bus.flush_all) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == INDEX_WIDTH'(DEPTH - 1)) begin
                        state     <= IDLE;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    flush_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_valid_data_array.sv
// tb/tb_valid_data_array.sv - directed self-checking bench for valid_data_array
module tb_valid_data_array;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    valid_data_array_if #(.WIDTH(128), .INDEX_WIDTH(3)) bus ();

    valid_data_array #(.WIDTH(128), .INDEX_WIDTH(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference state: plain arrays, flush modelled as a position walking 0..7.
    bit [127:0] m_data [8];
    bit         m_valid [8];
    bit         m_busy;
    int         m_pos;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) m_valid[i] <= 1'b0;
            m_busy <= 1'b0;
            m_pos  <= 0;
        end else if (m_busy) begin
            m_valid[m_pos] <= 1'b0;
            if (m_pos == 7) begin
                m_busy <= 1'b0;
                m_pos  <= 0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end else begin
            if (bus.write) begin
                for (int b = 0; b < 16; b++)
                    if (bus.byte_en[b]) m_data[bus.index][8*b +: 8] <= bus.datain[8*b +: 8];
                if (bus.byte_en != 16'h0) m_valid[bus.index] <= 1'b1;
            end
            if (bus.invalidate) m_valid[bus.index] <= 1'b0;
            if (bus.flush_all) begin
                m_busy <= 1'b1;
                m_pos  <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        check("model dataout", bus.dataout, m_data[bus.index]);
        check("model valid_out", {127'b0, bus.valid_out}, {127'b0, (m_busy ? 1'b0 : m_valid[bus.index])});
        check("model busy", {127'b0, bus.busy}, {127'b0, m_busy});
    end

    task automatic cyc(input logic w, input logic [2:0] idx, input logic [127:0] din,
                       input logic [15:0] be, input logic inv, input logic fl);
        bus.write      = w;
        bus.index      = idx;
        bus.datain     = din;
        bus.byte_en    = be;
        bus.invalidate = inv;
        bus.flush_all  = fl;
        @(negedge clk);
    endtask

    task automatic expect_lit(input string name, input logic [2:0] idx,
                              input logic [127:0] exp_d, input logic exp_v);
        bus.write      = 1'b0;
        bus.invalidate = 1'b0;
        bus.flush_all  = 1'b0;
        bus.byte_en    = 16'h0;
        bus.index      = idx;
        #3;
        check({name, " data"}, bus.dataout, exp_d);
        check({name, " valid"}, {127'b0, bus.valid_out}, {127'b0, exp_v});
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        #3;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            #3;
            n++;
        end
        check({name, " idle within bound"}, {127'b0, bus.busy}, 128'h0);
    endtask

    function automatic logic [127:0] pat(input int i);
        logic [7:0] b;
        b = 8'(8'h10 + i);
        return {16{b}};
    endfunction

    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] P5   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    initial begin
        int busy_cycles;
        bus.write = 1'b0; bus.index = 3'd0; bus.datain = '0;
        bus.byte_en = 16'h0; bus.invalidate = 1'b0; bus.flush_all = 1'b0;
        @(negedge clk);
        #3;
        check("reset busy", {127'b0, bus.busy}, 128'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) expect_lit("power-up", 3'(i), 128'h0, 1'b0);

        // Partial write: only byte 0 cleared.
        cyc(1, 3'd2, ONES, 16'hFFFF, 0, 0);
        cyc(1, 3'd2, 128'h0, 16'h0001, 0, 0);
        expect_lit("partial", 3'd2, {{120{1'b1}}, 8'h00}, 1'b1);
        cyc(1, 3'd3, ONES, 16'hA5A5, 0, 0);
        expect_lit("sparse be", 3'd3, 128'hFF00FF0000FF00FF_FF00FF0000FF00FF, 1'b1);

        // Write + invalidate on the same entry.
        cyc(1, 3'd5, P5, 16'hFFFF, 1, 0);
        expect_lit("conflict", 3'd5, P5, 1'b0);

        // byte_en=0 writes touch nothing.
        cyc(1, 3'd5, ONES, 16'h0000, 0, 0);
        expect_lit("be0 invalid", 3'd5, P5, 1'b0);
        cyc(1, 3'd6, ONES, 16'h0000, 0, 0);
        expect_lit("be0 fresh", 3'd6, 128'h0, 1'b0);

        cyc(0, 3'd2, 128'h0, 16'h0, 1, 0);
        expect_lit("invalidate", 3'd2, {{120{1'b1}}, 8'h00}, 1'b0);

        // Full flush with writes attempted while busy.
        for (int i = 0; i < 8; i++) cyc(1, 3'(i), pat(i), 16'hFFFF, 0, 0);
        for (int i = 0; i < 8; i++) expect_lit("filled", 3'(i), pat(i), 1'b1);
        cyc(0, 3'd0, 128'h0, 16'h0, 0, 1);
        busy_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            bus.write = 1'b1; bus.index = 3'd0; bus.datain = 128'hDEAD;
            bus.byte_en = 16'hFFFF; bus.invalidate = 1'b1; bus.flush_all = 1'b1;
            #3;
            if (!bus.busy) begin
                bus.write = 1'b0; bus.invalidate = 1'b0; bus.flush_all = 1'b0;
                break;
            end
            busy_cycles++;
            @(negedge clk);
        end
        @(negedge clk);
        check("flush busy cycles", 128'(busy_cycles), 128'd8);
        for (int i = 0; i < 8; i++) expect_lit("after flush", 3'(i), pat(i), 1'b0);

        // Flush requested together with a write to entry 7.
        cyc(1, 3'd7, P5, 16'hFFFF, 0, 1);
        expect_lit("flush+write busy", 3'd7, P5, 1'b0);
        wait_idle("flush+write");
        @(negedge clk);
        expect_lit("flush+write done", 3'd7, P5, 1'b0);

        // Reset during the third flush cycle.
        for (int i = 0; i < 4; i++) cyc(1, 3'(i), ~pat(i), 16'hFFFF, 0, 0);
        cyc(0, 3'd0, 128'h0, 16'h0, 0, 1);
        cyc(0, 3'd1, 128'h0, 16'h0, 0, 0);
        cyc(0, 3'd2, 128'h0, 16'h0, 0, 0);
        reset_n = 1'b0;
        #3;
        check("reset mid-flush busy", {127'b0, bus.busy}, 128'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) expect_lit("after reset", 3'(i), ~pat(i), 1'b0);
        expect_lit("after reset hi", 3'd7, P5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
